// File: rtl/ddr_packet_reader_256.sv
// ddr_packet_reader_256: Avalon-MM burst reader that unpacks 256-bit beats into a 32-bit word stream.
// Optional readdatavalid watchdog enabled by defining DDR_RD_TIMEOUT_EN.
module ddr_packet_reader_256 #(
    parameter int ADDR_W      = 25,
    parameter int DATA_W      = 256,
    parameter int WORD_W      = 32,
    parameter int MAX_BURST   = 8,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [15:0]       num_beats,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] amm_addr,
    output logic              amm_read,
    output logic [6:0]        amm_burstcount,
    output logic [31:0]       amm_byteenable,
    input  logic              amm_ready,
    input  logic [DATA_W-1:0] amm_readdata,
    input  logic              amm_readdatavalid,
    output logic [WORD_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last
);
    localparam int PW = $clog2(MAX_BURST);
    localparam int CW = PW + 1;
    localparam int NW = DATA_W / WORD_W;
    localparam int XW = $clog2(NW);
    typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       rem_q, rem_d, urem_q, urem_d;
    logic [6:0]        outst_q, outst_d, len;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [PW-1:0]     wr_q, wr_d, rd_q, rd_d;
    logic [DATA_W-1:0] mem_q [MAX_BURST];
    logic [DATA_W-1:0] buf_q, buf_d;
    logic [XW-1:0]     widx_q, widx_d;
    logic              buf_v_q, buf_v_d, last_q, last_d, err_q, err_d, done_q, done_d;
    logic [7:0]        credits;
    logic              accept, push, pop, take;
`ifdef DDR_RD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0]     wd_q, wd_d;
`endif

    // Burst sizing and credit check: never request more than the FIFO can absorb
    always_comb begin
        len = (rem_q < 16'(MAX_BURST)) ? rem_q[6:0] : 7'(MAX_BURST);
        credits = 8'(MAX_BURST) - 8'(cnt_q) - {1'b0, outst_q};
        amm_read = (state_q == REQ) && (credits >= {1'b0, len});
        accept = amm_read && amm_ready;
        push = amm_readdatavalid && (outst_q != 7'd0);
        take = buf_v_q && out_ready;
        pop = (cnt_q != '0) && (!buf_v_q || (take && widx_q == XW'(NW - 1)));
    end

    // Next-state for FSM, counters, FIFO pointers and unpacker
    always_comb begin
        state_d = state_q;
        addr_d = addr_q;
        rem_d = rem_q;
        urem_d = urem_q;
        err_d = err_q;
        done_d = 1'b0;
        outst_d = outst_q + (accept ? len : 7'd0) - (push ? 7'd1 : 7'd0);
        cnt_d = cnt_q + CW'(push) - CW'(pop);
        wr_d = wr_q + PW'(push);
        rd_d = rd_q + PW'(pop);
        buf_d = buf_q;
        buf_v_d = buf_v_q;
        widx_d = widx_q;
        last_d = last_q;
        if (take) begin
            widx_d = widx_q + XW'(1);
            buf_v_d = (widx_q != XW'(NW - 1));
        end
        if (pop) begin
            buf_d = mem_q[rd_q];
            buf_v_d = 1'b1;
            widx_d = '0;
            last_d = (urem_q == 16'd1);
            urem_d = urem_q - 16'd1;
        end
        case (state_q)
            IDLE: begin
                if (start) begin
                    err_d = 1'b0;
                    done_d = (num_beats == 16'd0);
                    if (num_beats != 16'd0) begin
                        state_d = REQ;
                        addr_d = base_addr;
                        rem_d = num_beats;
                        urem_d = num_beats;
                    end
                end
            end
            REQ: begin
                if (accept) begin
                    addr_d = addr_q + ADDR_W'(len);
                    rem_d = rem_q - 16'(len);
                    state_d = (rem_q == 16'(len)) ? DRAIN : REQ;
                end
            end
            default: begin
                if (outst_q == 7'd0 && cnt_q == '0 && !buf_v_q) begin
                    done_d = 1'b1;
                    state_d = IDLE;
                end
            end
        endcase
        if (amm_readdatavalid && outst_q == 7'd0)
            err_d = 1'b1;
`ifdef DDR_RD_TIMEOUT_EN
        wd_d = (outst_q != 7'd0 && !amm_readdatavalid) ? wd_q + TW'(1) : '0;
        if (outst_q != 7'd0 && !amm_readdatavalid && wd_q == TW'(TIMEOUT_CYC - 1)) begin
            err_d = 1'b1;
            done_d = 1'b1;
            state_d = IDLE;
            rem_d = '0;
            urem_d = '0;
            outst_d = '0;
            cnt_d = '0;
            wr_d = '0;
            rd_d = '0;
            buf_v_d = 1'b0;
            widx_d = '0;
            last_d = 1'b0;
            wd_d = '0;
        end
`endif
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q <= '0;
            rem_q <= '0;
            urem_q <= '0;
            outst_q <= '0;
            cnt_q <= '0;
            wr_q <= '0;
            rd_q <= '0;
            buf_q <= '0;
            buf_v_q <= 1'b0;
            widx_q <= '0;
            last_q <= 1'b0;
            err_q <= 1'b0;
            done_q <= 1'b0;
`ifdef DDR_RD_TIMEOUT_EN
            wd_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            addr_q <= addr_d;
            rem_q <= rem_d;
            urem_q <= urem_d;
            outst_q <= outst_d;
            cnt_q <= cnt_d;
            wr_q <= wr_d;
            rd_q <= rd_d;
            buf_q <= buf_d;
            buf_v_q <= buf_v_d;
            widx_q <= widx_d;
            last_q <= last_d;
            err_q <= err_d;
            done_q <= done_d;
`ifdef DDR_RD_TIMEOUT_EN
            wd_q <= wd_d;
`endif
        end
    end

    // Beat FIFO storage; contents are meaningless until pointers say otherwise
    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_q] <= amm_readdata;
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign error = err_q;
    assign amm_addr = addr_q;
    assign amm_burstcount = len;
    assign amm_byteenable = '1;
    assign out_data = buf_q[int'(widx_q) * WORD_W +: WORD_W];
    assign out_valid = buf_v_q;
    assign out_last = buf_v_q && last_q && (widx_q == XW'(NW - 1));
endmodule

// File: tb/tb_ddr_packet_reader_256.sv
// tb_ddr_packet_reader_256: scoreboard bench with a randomized Avalon slave model.
module tb_ddr_packet_reader_256;
    typedef struct {logic [31:0] d; logic l;} exp_t;
    typedef struct {logic [24:0] a; logic [6:0] n;} req_t;

    logic         clk, reset, start, busy, done, error;
    logic [24:0]  base_addr, amm_addr;
    logic [15:0]  num_beats;
    logic         amm_read, amm_ready, amm_readdatavalid;
    logic [6:0]   amm_burstcount;
    logic [31:0]  amm_byteenable, out_data;
    logic [255:0] amm_readdata;
    logic         out_valid, out_ready, out_last;

    exp_t        exp_q[$];
    req_t        req_q[$];
    logic [24:0] pend_q[$];
    int n_checks = 0, n_fail = 0;
    int rdy_pct = 100, rdv_pct = 100, or_pct = 100;
    int stall_left = 0, beats_acc = 0, words_tk = 0;
    bit withhold = 0, inject = 0, chk_stall = 0;

    ddr_packet_reader_256 dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .num_beats(num_beats),
        .busy(busy), .done(done), .error(error), .amm_addr(amm_addr), .amm_read(amm_read),
        .amm_burstcount(amm_burstcount), .amm_byteenable(amm_byteenable), .amm_ready(amm_ready),
        .amm_readdata(amm_readdata), .amm_readdatavalid(amm_readdatavalid),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] wv(input logic [24:0] a, input int k);
        return {a, 7'(k)} ^ 32'hA5C3_0000;
    endfunction

    function automatic logic [255:0] beat(input logic [24:0] a);
        logic [255:0] b;
        for (int k = 0; k < 8; k++) b[k*32 +: 32] = wv(a, k);
        return b;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reference model: words in address order, LSB word first; bursts of min(rem,8)
    task automatic load(input logic [24:0] base, input int nb);
        logic [24:0] a;
        exp_t e;
        req_t r;
        int rem;
        for (int b = 0; b < nb; b++) begin
            a = base + 25'(b);
            for (int k = 0; k < 8; k++) begin
                e.d = wv(a, k);
                e.l = (b == nb - 1) && (k == 7);
                exp_q.push_back(e);
            end
        end
        a = base;
        rem = nb;
        while (rem > 0) begin
            r.a = a;
            r.n = 7'(rem < 8 ? rem : 8);
            req_q.push_back(r);
            a = a + 25'(r.n);
            rem -= int'(r.n);
        end
    endtask

    task automatic pulse_start(input logic [24:0] base, input int nb);
        base_addr = base;
        num_beats = 16'(nb);
        start = 1;
        cyc(1);
        start = 0;
    endtask

    task automatic flush();
        exp_q.delete();
        req_q.delete();
        pend_q.delete();
        beats_acc = 0;
        words_tk = 0;
    endtask

    task automatic do_reset();
        reset = 1;
        cyc(1);
        check("rst_busy", busy, 0);
        check("rst_read", amm_read, 0);
        check("rst_valid", out_valid, 0);
        reset = 0;
        flush();
    endtask

    task automatic xfer(input logic [24:0] base, input int nb);
        int t = 0;
        load(base, nb);
        pulse_start(base, nb);
        check("err_clear", error, 0);
        while (!done && t < 5000) begin
            cyc(1);
            t++;
        end
        check("done", done, 1);
        cyc(1);
        check("done_pulse", done, 0);
        check("busy_end", busy, 0);
        check("words_left", 64'(exp_q.size()), 0);
        check("reqs_left", 64'(req_q.size()), 0);
    endtask

    // Slave and sink drivers: waitrequest, beat return, out_ready
    initial forever begin
        @(posedge clk);
        #1;
        out_ready = ($urandom_range(99) < or_pct);
        if (amm_read && stall_left > 0) begin
            amm_ready = 0;
            stall_left--;
        end else amm_ready = ($urandom_range(99) < rdy_pct);
        if (inject) begin
            amm_readdatavalid = 1;
            amm_readdata = '0;
            inject = 0;
        end else if (pend_q.size() != 0 && !withhold && $urandom_range(99) < rdv_pct) begin
            amm_readdatavalid = 1;
            amm_readdata = beat(pend_q.pop_front());
        end else amm_readdatavalid = 0;
    end

    // Request monitor: hold stability under waitrequest and request sequence
    initial begin
        bit held = 0;
        int stalls = 0;
        logic [24:0] h_a;
        logic [6:0] h_n;
        req_t r;
        forever begin
            @(negedge clk);
            if (reset || !amm_read) begin
                held = 0;
                stalls = 0;
            end else begin
                if (held) begin
                    check("hold_addr", amm_addr, h_a);
                    check("hold_burst", amm_burstcount, h_n);
                end
                if (amm_ready) begin
                    check("req_expected", req_q.size() != 0, 1);
                    if (req_q.size() != 0) begin
                        r = req_q.pop_front();
                        check("req_addr", amm_addr, r.a);
                        check("req_burst", amm_burstcount, r.n);
                    end
                    for (int i = 0; i < int'(amm_burstcount); i++) pend_q.push_back(amm_addr + 25'(i));
                    beats_acc += int'(amm_burstcount);
                    check("fifo_bound", (beats_acc - words_tk / 8) <= 9, 1);
                    if (chk_stall) begin
                        check("stall_accept", stalls, 5);
                        chk_stall = 0;
                    end
                    held = 0;
                    stalls = 0;
                end else begin
                    held = 1;
                    h_a = amm_addr;
                    h_n = amm_burstcount;
                    stalls++;
                end
            end
        end
    end

    // Output monitor: scoreboard pop and stability while stalled
    initial begin
        bit was_stall = 0;
        logic [31:0] h_d;
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) was_stall = 0;
            else if (out_valid) begin
                if (was_stall) check("data_stable", out_data, h_d);
                if (out_ready) begin
                    check("word_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("word_data", out_data, e.d);
                        check("word_last", out_last, e.l);
                    end
                    words_tk++;
                    was_stall = 0;
                end else begin
                    was_stall = 1;
                    h_d = out_data;
                end
            end else was_stall = 0;
        end
    end

    initial begin
        int t;
        reset = 1;
        start = 0;
        base_addr = '0;
        num_beats = '0;
        amm_ready = 0;
        amm_readdatavalid = 0;
        amm_readdata = '0;
        out_ready = 0;
        cyc(3);
        check("init_busy", busy, 0);
        check("init_done", done, 0);
        check("init_error", error, 0);
        check("init_read", amm_read, 0);
        check("init_valid", out_valid, 0);
        check("init_be", amm_byteenable, 32'hFFFF_FFFF);
        reset = 0;
        cyc(1);
        xfer(25'd1, 3);
        or_pct = 50;
        xfer(25'd0, 20);
        or_pct = 100;
        stall_left = 5;
        chk_stall = 1;
        xfer(25'd40, 2);
        check("stall_seen", chk_stall, 0);
        pulse_start(25'd7, 0);
        check("zero_done", done, 1);
        check("zero_busy", busy, 0);
        check("zero_read", amm_read, 0);
        cyc(1);
        check("zero_done_pulse", done, 0);
        check("zero_read2", amm_read, 0);
        inject = 1;
        cyc(3);
        check("stray_err", error, 1);
        for (int i = 0; i < 6; i++) begin
            rdy_pct = $urandom_range(30, 100);
            rdv_pct = $urandom_range(30, 100);
            or_pct = $urandom_range(30, 100);
            xfer(i == 0 ? 25'h1FF_FFFD : 25'($urandom), $urandom_range(1, 20));
        end
        rdy_pct = 100;
        rdv_pct = 100;
        or_pct = 100;
        withhold = 1;
        load(25'd200, 4);
        pulse_start(25'd200, 4);
        t = 0;
`ifdef DDR_RD_TIMEOUT_EN
        while (!done && t < 1500) begin
            cyc(1);
            t++;
        end
        check("tmo_done", done, 1);
        check("tmo_late_enough", t >= 1000, 1);
        check("tmo_error", error, 1);
        check("tmo_busy", busy, 0);
        flush();
`else
        cyc(1100);
        check("wait_busy", busy, 1);
        check("wait_done", done, 0);
        do_reset();
`endif
        or_pct = 0;
        load(25'd300, 16);
        pulse_start(25'd300, 16);
        t = 0;
        while (beats_acc == 0 && t < 100) begin
            cyc(1);
            t++;
        end
        check("mid_accepted", beats_acc != 0, 1);
        cyc(2);
        do_reset();
        withhold = 0;
        or_pct = 100;
        inject = 1;
        cyc(3);
        check("late_err", error, 1);
        xfer(25'd500, 5);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
